counter_run_ctrl: RTL
=====================

// Module: counter_run_ctrl
// PURPOSE
//  Sequencer for the shared N-bit up-counter (negedge-clocked, async rst, en).
//  Clears the counter, issues prescaled en pulses, compares the count against a
//  latched target, and signals expiry. Supports one-shot and periodic modes,
//  pause and stop. Sits between the control FSM/user inputs and the counter.
// PARAMETERS
//  N     8  counter/target width; must equal the counter's N
//  P     8  prescale width; en pulse every (prescale+1) clk cycles
//  LAPW  8  width of periodic expiry (lap) counter
// PORTS
//  clk       in   1     clock; all state on posedge
//  rst       in   1     asynchronous reset, active-high
//  start     in   1     level; sampled only in IDLE
//  stop      in   1     level; abort from any state
//  pause     in   1     level; holds RUN while high
//  periodic  in   1     sampled with start: 1=periodic, 0=one-shot
//  target    in   N     terminal count, latched at start
//  prescale  in   P     tick divider, latched at start
//  cnt_q     in   N     counter Q
//  cnt_en    out  1     counter en; registered one-cycle pulses
//  cnt_rst   out  1     counter rst = rst | cnt_rst_q (cnt_rst_q registered)
//  busy      out  1     state != IDLE
//  paused    out  1     state == PAUSE
//  done      out  1     one-cycle expiry pulse, registered
//  laps      out  LAPW  periodic expiries since start; wraps to 0
// BEHAVIOUR
//  Reset: state=IDLE; cnt_en, cnt_rst_q, done, laps, psc, latches = 0;
//   cnt_rst=1 while rst high.
//  States: IDLE, CLR, RUN, PAUSE. Priority per posedge: stop > pause > start.
//  stop (any state): ->IDLE, cnt_rst_q<=1 one cycle, cnt_en<=0; no done.
//  IDLE: start=1 -> CLR; latch target/prescale/periodic; cnt_rst_q<=1; laps<=0.
//   Other IDLE cycles: cnt_rst_q<=0, counter holds its value.
//  CLR: cnt_rst_q<=0, psc<=0 -> RUN (pause ignored in CLR).
//  RUN, pause=1: -> PAUSE; psc, cnt_q frozen; cnt_en<=0.
//  RUN, pause=0: if psc!=prescale_l: psc<=psc+1, cnt_en<=0.
//   Else (tick): psc<=0; if cnt_q==target_l: expire, else cnt_en<=1.
//  Expire: done<=1, cnt_en<=0. One-shot: ->IDLE, count stays at target.
//   Periodic: cnt_rst_q<=1, laps<=laps+1 (mod 2^LAPW), ->CLR.
//  PAUSE: pause=0 -> RUN, psc resumes from held value; start ignored.
//  start while busy: ignored. target/prescale changes after start: no effect.
//  Timing: cnt_en registered at posedge k -> counter increments at following
//   negedge -> new cnt_q visible at posedge k+1 (no extra wait state).
//  Latency: start sampled at edge k -> done high in cycle after edge
//   k+1+(T+1)*(S+1), T=target_l, S=prescale_l; pauses add their length.
//  Periodic period = (T+1)*(S+1)+1 cycles (includes CLR).
//  target=0: expires at first tick, no en pulses. target=2^N-1: no wrap;
//   expiry before counter can overflow.
//  Reset mid-run: immediate IDLE, counter cleared via cnt_rst, done not raised.
// TESTING
//  1 one-shot T=3,S=0, start at edge k -> cnt_en pulses k+2..k+4, done in
//    cycle after k+5, busy=0 after, cnt_q holds 3.
//  2 T=2,S=3 one-shot -> cnt_en pulses every 4 cycles, done after edge
//    k+1+12=k+13; exactly 2 en pulses.
//  3 periodic T=1,S=0, run 3 periods -> done every 3 cycles, laps=1,2,3,
//    cnt_rst pulse after each done; stop -> IDLE, laps held.
//  4 T=5,S=1, pause 7 cycles after 2nd en pulse -> no en, psc/cnt_q frozen,
//    done delayed exactly 7 cycles vs scenario without pause.
//  5 T=0 -> done after edge k+2, zero en pulses; start+stop same edge in IDLE
//    -> stays IDLE; stop during PAUSE -> IDLE, no done.
//  6 async rst mid-RUN (between edges) -> busy=0, cnt_rst=1, cnt_q=0
//    immediately; target change while RUN -> expiry uses latched T.

Source files
------------

// File: rtl/counter_run_ctrl.sv
// Run sequencer for the shared negedge-clocked up-counter: clears it, issues prescaled
// enable pulses, compares the count against a latched target, and signals expiry.
module counter_run_ctrl #(
  parameter int N    = 8,
  parameter int P    = 8,
  parameter int LAPW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            stop,
  input  logic            pause,
  input  logic            periodic,
  input  logic [N-1:0]    target,
  input  logic [P-1:0]    prescale,
  input  logic [N-1:0]    cnt_q,
  output logic            cnt_en,
  output logic            cnt_rst,
  output logic            busy,
  output logic            paused,
  output logic            done,
  output logic [LAPW-1:0] laps
);

  // state | meaning
  // IDLE  | waiting for start; counter holds its last value
  // CLR   | counter held in reset for one cycle, prescaler cleared
  // RUN   | prescaling and counting toward the latched target
  // PAUSE | prescaler and count frozen until pause drops
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLR   = 2'd1,
    RUN   = 2'd2,
    PAUSE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            cnt_en_q, cnt_en_d;
  logic            cnt_rst_q, cnt_rst_d;
  logic            done_q, done_d;
  logic [LAPW-1:0] laps_q, laps_d;
  logic [P-1:0]    psc_q, psc_d;
  logic [N-1:0]    target_l_q, target_l_d;
  logic [P-1:0]    prescale_l_q, prescale_l_d;
  logic            periodic_l_q, periodic_l_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_en_q     <= 1'b0;
      cnt_rst_q    <= 1'b0;
      done_q       <= 1'b0;
      laps_q       <= '0;
      psc_q        <= '0;
      target_l_q   <= '0;
      prescale_l_q <= '0;
      periodic_l_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_en_q     <= cnt_en_d;
      cnt_rst_q    <= cnt_rst_d;
      done_q       <= done_d;
      laps_q       <= laps_d;
      psc_q        <= psc_d;
      target_l_q   <= target_l_d;
      prescale_l_q <= prescale_l_d;
      periodic_l_q <= periodic_l_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_en_d     = 1'b0;
    cnt_rst_d    = 1'b0;
    done_d       = 1'b0;
    laps_d       = laps_q;
    psc_d        = psc_q;
    target_l_d   = target_l_q;
    prescale_l_d = prescale_l_q;
    periodic_l_d = periodic_l_q;

    if (stop) begin
      state_d   = IDLE;
      cnt_rst_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d      = CLR;
            target_l_d   = target;
            prescale_l_d = prescale;
            periodic_l_d = periodic;
            cnt_rst_d    = 1'b1;
            laps_d       = '0;
          end
        end
        CLR: begin
          psc_d   = '0;
          state_d = RUN;
        end
        RUN, PAUSE: begin
          if (pause) begin
            state_d = PAUSE;
          end else begin
            // The resume edge also advances, so a pause delays expiry by exactly its length.
            state_d = RUN;
            if (psc_q != prescale_l_q) begin
              psc_d = psc_q + P'(1);
            end else begin
              psc_d = '0;
              if (cnt_q == target_l_q) begin
                done_d = 1'b1;
                if (periodic_l_q) begin
                  cnt_rst_d = 1'b1;
                  laps_d    = laps_q + LAPW'(1);
                  state_d   = CLR;
                end else begin
                  state_d = IDLE;
                end
              end else begin
                cnt_en_d = 1'b1;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign cnt_en  = cnt_en_q;
  assign cnt_rst = rst | cnt_rst_q;
  assign busy    = (state_q != IDLE);
  assign paused  = (state_q == PAUSE);
  assign done    = done_q;
  assign laps    = laps_q;

endmodule
